// File: rtl/sr_data_fifo.sv
// sr_data_fifo: first-word-fall-through register FIFO that buffers register values between instructions.
// Define SR_FIFO_ERR_EN to add sticky errOverflow/errUnderflow flags.
module sr_data_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  writeEnable,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  readEnable,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
`ifdef SR_FIFO_ERR_EN
    ,
    output logic                  errOverflow,
    output logic                  errUnderflow
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  push_ok, pop_ok;
    assign full     = cnt_q == FULL_CNT;
    assign empty    = cnt_q == '0;
    assign count    = cnt_q;
    assign readData = empty ? '0 : mem_q[rd_ptr_q];
    // Popping frees the head slot before the edge, so a push is still legal when full.
    assign push_ok  = writeEnable & (~full | readEnable);
    assign pop_ok   = readEnable & ~empty;
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = (push_ok & ~pop_ok) ? cnt_q + 1'b1 :
                   (pop_ok & ~push_ok) ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem_q[wr_ptr_q] <= writeData;
    end
`ifdef SR_FIFO_ERR_EN
    logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
    always_comb begin
        err_ovf_d = err_ovf_q | (writeEnable & full & ~readEnable);
        err_udf_d = err_udf_q | (readEnable & empty);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end
    assign errOverflow  = err_ovf_q;
    assign errUnderflow = err_udf_q;
`endif
endmodule

// File: tb/tb_sr_data_fifo.sv
// tb_sr_data_fifo: directed and random stimulus against a queue model; a negedge monitor scores pops and status.
module tb_sr_data_fifo;
    localparam int DW = 32;
    localparam int DL = 3;
    localparam int DEPTH = 1 << DL;
    logic          clk = 0, reset = 1, writeEnable = 0, readEnable = 0;
    logic [DW-1:0] writeData = '0, readData;
    logic          full, empty;
    logic [DL:0]   count;
    int            n_checks = 0, n_fail = 0;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb_q[$];
    int            exp_cnt = 0;
    bit            m_ovf = 0, m_udf = 0, exp_ovf = 0, exp_udf = 0;
`ifdef SR_FIFO_ERR_EN
    logic errOverflow, errUnderflow;
`endif
    sr_data_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset(reset), .writeEnable(writeEnable), .writeData(writeData),
        .readEnable(readEnable), .readData(readData), .full(full), .empty(empty), .count(count)
`ifdef SR_FIFO_ERR_EN
        , .errOverflow(errOverflow), .errUnderflow(errUnderflow)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    // Drives one cycle's request and advances the model as the next edge will.
    task automatic drive(input bit we, input logic [DW-1:0] wd, input bit re);
        int  pre;
        bit  pop_ok, push_ok;
        @(posedge clk);
        #1;
        writeEnable = we;
        writeData   = wd;
        readEnable  = re;
        pre     = mq.size();
        exp_cnt = pre;
        exp_ovf = m_ovf;
        exp_udf = m_udf;
        pop_ok  = re && pre > 0;
        push_ok = we && (pre < DEPTH || re);
        if (pop_ok) sb_q.push_back(mq.pop_front());
        if (push_ok) mq.push_back(wd);
        m_ovf = m_ovf | (we && pre == DEPTH && !re);
        m_udf = m_udf | (re && pre == 0);
    endtask
    always @(negedge clk) begin
        chk("count", count, exp_cnt);
        chk("empty", empty, exp_cnt == 0);
        chk("full", full, exp_cnt == DEPTH);
        if (exp_cnt == 0) chk("read_empty", readData, 0);
`ifdef SR_FIFO_ERR_EN
        chk("err_ovf", errOverflow, exp_ovf);
        chk("err_udf", errUnderflow, exp_udf);
`endif
        if (readEnable && !empty) begin
            if (sb_q.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("pop_data", readData, sb_q.pop_front());
        end
    end
    task automatic do_reset();
        drive(0, 0, 0);
        #2;
        mq.delete();
        sb_q.delete();
        exp_cnt = 0;
        m_ovf = 0; m_udf = 0; exp_ovf = 0; exp_udf = 0;
        reset = 1;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_read", readData, 0);
        chk("rst_full", full, 0);
        @(posedge clk);
        #1;
        reset = 0;
    endtask
    initial begin
        @(posedge clk);
        #1;
        reset = 0;
        for (int i = 0; i < 5; i++) drive(1, $urandom, 0);
        do_reset();
        drive(1, 32'hAAAA0001, 0);
        drive(0, 0, 1);
        for (int i = 1; i <= 3; i++) drive(1, 32'h11 * i, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1);
        drive(0, 0, 0);
        for (int i = 1; i <= 9; i++) drive(1, i, 0);
        drive(0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 0, 1);
        do_reset();
        for (int i = 1; i <= 8; i++) drive(1, i, 0);
        drive(1, 32'h99, 1);
        for (int i = 0; i < 8; i++) drive(0, 0, 1);
        drive(0, 0, 1);
        drive(1, 32'h5, 1);
        drive(0, 0, 1);
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 32'h100 + i, 0);
        for (int i = 0; i < 20; i++) drive(1, 32'h200 + i, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i / 50) % 3;
            drive($urandom_range(0, 3) < (bias == 0 ? 3 : 1), $urandom,
                  $urandom_range(0, 3) < (bias == 1 ? 3 : 1));
        end
        while (mq.size() > 0) drive(0, 0, 1);
        drive(0, 0, 0);
        drive(0, 0, 0);
        @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
